// File: rtl/game_timer_bcd.sv
// game_timer_bcd: countdown game clock holding M:ST:SU as three BCD digits.
// Ports: clk, reset (async, active-high); start/pause/load one-cycle pulses;
//        min_digit/sec_tens/sec_ones BCD digits for the digit selector A/B/C;
//        running (RUN state), done (DONE state), warn (last-ten-seconds flag).
// Optional: define GAME_TIMER_WARN_EN to build the warn indicator; otherwise warn is 0.
module game_timer_bcd #(
  parameter int TICK_DIV    = 100000000,
  parameter int START_MIN   = 2,
  parameter int START_SEC_T = 0,
  parameter int START_SEC_U = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  output logic [3:0] min_digit,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done,
  output logic       warn
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [3:0] P_MIN = 4'(START_MIN);
  localparam logic [3:0] P_ST  = 4'(START_SEC_T);
  localparam logic [3:0] P_SU  = 4'(START_SEC_U);
  localparam bit P_ZERO = (P_MIN == 4'd0) && (P_ST == 4'd0) && (P_SU == 4'd0);
`ifdef GAME_TIMER_WARN_EN
  localparam bit WARN_EN = 1'b1;
`else
  localparam bit WARN_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        r_state;
  logic [PW-1:0] r_pre;
  logic [3:0]    r_min, r_st, r_su;
  logic          r_running, r_done, r_warn;

  logic       w_tick, w_su_b, w_st_b, w_zero, w_low;
  logic [3:0] w_min, w_st, w_su;

  // Decremented time, with BCD borrow rippling units -> tens -> minutes.
  assign w_tick = r_pre == PW'(TICK_DIV - 1);
  assign w_su_b = r_su == 4'd0;
  assign w_st_b = w_su_b && (r_st == 4'd0);
  assign w_su   = w_su_b ? 4'd9 : r_su - 4'd1;
  assign w_st   = w_su_b ? ((r_st == 4'd0) ? 4'd5 : r_st - 4'd1) : r_st;
  assign w_min  = w_st_b ? r_min - 4'd1 : r_min;
  assign w_low  = (w_min == 4'd0) && (w_st == 4'd0);
  assign w_zero = w_low && (w_su == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pre     <= '0;
      r_min     <= P_MIN;
      r_st      <= P_ST;
      r_su      <= P_SU;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_warn    <= 1'b0;
    end else if (load) begin
      r_state   <= IDLE;
      r_pre     <= '0;
      r_min     <= P_MIN;
      r_st      <= P_ST;
      r_su      <= P_SU;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_warn    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state   <= P_ZERO ? DONE : RUN;
          r_pre     <= '0;
          r_running <= !P_ZERO;
          r_done    <= P_ZERO;
          r_warn    <= WARN_EN && !P_ZERO && (P_MIN == 4'd0) && (P_ST == 4'd0);
        end
        RUN: begin
          r_pre <= w_tick ? '0 : r_pre + PW'(1);
          if (w_tick) begin
            r_min <= w_min;
            r_st  <= w_st;
            r_su  <= w_su;
          end
          // Reaching 0:00 wins over a simultaneous pause.
          if (w_tick && w_zero) begin
            r_state   <= DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_warn    <= 1'b0;
          end else begin
            if (w_tick) r_warn <= WARN_EN && w_low;
            if (pause) begin
              r_state   <= PAUSE;
              r_running <= 1'b0;
            end
          end
        end
        PAUSE: if (start || pause) begin
          r_state   <= RUN;
          r_running <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign min_digit = r_min;
  assign sec_tens  = r_st;
  assign sec_ones  = r_su;
  assign running   = r_running;
  assign done      = r_done;
  assign warn      = r_warn;
endmodule

// File: tb/tb_game_timer_bcd.sv
// tb_game_timer_bcd: scoreboard bench for game_timer_bcd (2:00 and 0:00 presets).
module tb_game_timer_bcd;
  localparam int TD = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
`ifdef GAME_TIMER_WARN_EN
  localparam bit WARN_EN = 1'b1;
`else
  localparam bit WARN_EN = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, pause = 1'b0, load = 1'b0;
  logic [3:0] min0, st0, su0, min1, st1, su1;
  logic run0, done0, warn0, run1, done1, warn1;

  game_timer_bcd #(.TICK_DIV(TD), .START_MIN(2), .START_SEC_T(0), .START_SEC_U(0)) u_dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .load(load),
    .min_digit(min0), .sec_tens(st0), .sec_ones(su0),
    .running(run0), .done(done0), .warn(warn0));

  game_timer_bcd #(.TICK_DIV(TD), .START_MIN(0), .START_SEC_T(0), .START_SEC_U(0)) u_zero (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .load(load),
    .min_digit(min1), .sec_tens(st1), .sec_ones(su1),
    .running(run1), .done(done1), .warn(warn1));

  always #5 clk = ~clk;

  int checks = 0, fails = 0, cyc = 0;
  logic [29:0] sb[$];
  logic [29:0] e;
  int m_secs[2] = '{120, 0};
  int m_st[2]   = '{S_IDLE, S_IDLE};
  int m_cnt[2]  = '{0, 0};
  int preset[2] = '{120, 0};

  // Reference model: remaining time in whole seconds plus a phase counter.
  function automatic void step(bit s, bit p, bit l, bit r);
    for (int i = 0; i < 2; i++) begin
      if (r || l) begin
        m_secs[i] = preset[i];
        m_st[i]   = S_IDLE;
        m_cnt[i]  = 0;
      end else case (m_st[i])
        S_IDLE: if (s) begin
          m_st[i]  = (m_secs[i] == 0) ? S_DONE : S_RUN;
          m_cnt[i] = 0;
        end
        S_RUN: begin
          if (m_cnt[i] == TD - 1) m_secs[i] = m_secs[i] - 1;
          m_cnt[i] = (m_cnt[i] + 1) % TD;
          if (m_secs[i] == 0) m_st[i] = S_DONE;
          else if (p) m_st[i] = S_PAUSE;
        end
        S_PAUSE: if (s || p) m_st[i] = S_RUN;
        default: ;
      endcase
    end
  endfunction

  function automatic logic [14:0] expv(int i);
    int s = m_secs[i];
    return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10), m_st[i] == S_RUN, m_st[i] == S_DONE,
            WARN_EN && (m_st[i] == S_RUN || m_st[i] == S_PAUSE) && (s < 10)};
  endfunction

  function automatic logic [14:0] gotv(int i);
    return (i == 0) ? {min0, st0, su0, run0, done0, warn0} : {min1, st1, su1, run1, done1, warn1};
  endfunction

  function automatic string fmt(logic [14:0] v);
    return $sformatf("%0d:%0d%0d run=%0b done=%0b warn=%0b", v[14:11], v[10:7], v[6:3], v[2], v[1], v[0]);
  endfunction

  task automatic cycle(input bit s, input bit p, input bit l);
    start = s;
    pause = p;
    load  = l;
    step(s, p, l, reset);
    sb.push_back({expv(1), expv(0)});
    @(negedge clk);
  endtask

  task automatic arst();
    #2 reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (gotv(i) !== expv(i)) begin
        fails++;
        $display("FAIL async_reset dut%0d: got %s expected %s", i, fmt(gotv(i)), fmt(expv(i)));
      end
    end
    cycle(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb_empty cycle %0d: no expectation queued", cyc);
      end else begin
        e = sb.pop_front();
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (gotv(i) !== e[i*15 +: 15]) begin
            fails++;
            $display("FAIL dut%0d cycle %0d: got %s expected %s", i, cyc, fmt(gotv(i)), fmt(e[i*15 +: 15]));
          end
        end
      end
    end
  end

  initial begin
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    repeat (20) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (6) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (300) cycle($urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (500) cycle(1'b0, 1'b0, 1'b0);
    repeat (20) cycle($urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (93) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, 1'b0);
    arst();
    repeat (5) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, 1'b0);
    start = 1'b0;
    pause = 1'b0;
    load  = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
